// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the writeback controller state encoding.
package sha256_pkg;

    localparam int HASH_WORDS = 8;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/hash_writeback_ctrl.sv
// Captures a finished digest and writes it to the output hash memory one word
// per cycle, holding the write under mem_stall and pulsing completion at the end.
module hash_writeback_ctrl
    import sha256_pkg::*;
#(
    parameter int HASH_LENGTH = HASH_WORDS,
    parameter int ADDR_W      = $clog2(HASH_LENGTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          digest_valid,
    input  logic [HASH_LENGTH*WORD_W-1:0] hash_vector,
    input  logic                          mem_stall,
    output logic                          digest_ready,
    output logic [WORD_W-1:0]             h_data,
    output logic                          h_write,
    output logic [ADDR_W-1:0]             h_output_address,
    output logic                          busy,
    output logic                          h_vector_complete
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(HASH_LENGTH - 1);

    wb_state_t                     state;
    logic [HASH_LENGTH*WORD_W-1:0] digest_reg;
    logic [ADDR_W-1:0]             counter;
    logic [ADDR_W-1:0]             next_idx;
    logic [WORD_W-1:0]             sel_word;
    logic                          accept;

    // LOAD presents word 0 (counter was cleared on entry); WRITE presents the following word.
    assign next_idx     = (state == WRITE) ? counter + 1'b1 : '0;
    assign sel_word     = digest_reg[next_idx*WORD_W +: WORD_W];
    assign accept       = h_write && !mem_stall;
    assign digest_ready = (state == IDLE);

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of state and counter within the same clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            // NOTE: the digest register is reset even though it is wide; the
            // reset state of the block is then fully defined for observation.
            digest_reg        <= '0;
            counter           <= '0;
            h_data            <= '0;
            h_write           <= 1'b0;
            h_output_address  <= '0;
            busy              <= 1'b0;
            h_vector_complete <= 1'b0;
        end else if (!enable) begin
            state             <= IDLE;
            counter           <= '0;
            h_write           <= 1'b0;
            h_output_address  <= '0;
            busy              <= 1'b0;
            h_vector_complete <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    h_vector_complete <= 1'b0;
                    if (digest_valid) begin
                        digest_reg <= hash_vector;
                        counter    <= '0;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    h_data           <= sel_word;
                    h_output_address <= '0;
                    h_write          <= 1'b1;
                    state            <= WRITE;
                end
                WRITE: begin
                    if (accept) begin
                        if (counter < LAST_IDX) begin
                            counter          <= next_idx;
                            h_data           <= sel_word;
                            h_output_address <= next_idx;
                        end else begin
                            h_write           <= 1'b0;
                            h_vector_complete <= 1'b1;
                            state             <= DONE;
                        end
                    end
                end
                DONE: begin
                    h_vector_complete <= 1'b0;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    h_write <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_writeback_ctrl.sv
// Directed bench for hash_writeback_ctrl: a cycle table for the basic sequence
// plus hand-written stall, isolation, ignored-start, abort and reset sequences.
module tb_hash_writeback_ctrl;
    import sha256_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         digest_valid = 1'b0;
    logic [255:0] hash_vector = '0;
    logic         mem_stall = 1'b0;
    logic         digest_ready;
    logic [31:0]  h_data;
    logic         h_write;
    logic [2:0]   h_output_address;
    logic         busy;
    logic         h_vector_complete;

    int checks = 0;
    int errors = 0;

    hash_writeback_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .digest_valid      (digest_valid),
        .hash_vector       (hash_vector),
        .mem_stall         (mem_stall),
        .digest_ready      (digest_ready),
        .h_data            (h_data),
        .h_write           (h_write),
        .h_output_address  (h_output_address),
        .busy              (busy),
        .h_vector_complete (h_vector_complete)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        dv;
        logic        stall;
        logic        exp_write;
        logic [2:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_complete;
        logic        exp_ready;
        logic        exp_busy;
    } vec_t;

    localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [255:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_digest(input logic [255:0] v);
        hash_vector  = v;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
    endtask

    // Wait (bounded) until word address a is on the write port.
    task automatic wait_addr(input logic [2:0] a);
        int n;
        n = 0;
        while (!(h_write && h_output_address == a) && n < 30) begin
            tick();
            n++;
        end
        check("wait_addr_timeout", 64'(n >= 30), 64'(0));
    endtask

    // Runs one writeback after send_digest, modelling expected address order,
    // optional stall on one address and an optional extra digest_valid pulse.
    task automatic drain(input logic [255:0] exp_vec, input int stall_addr, input int stall_len,
                         input int pulse_addr);
        int idx, stalls, wcycles, completes, n;
        bit pulsed;
        idx = 0; stalls = 0; wcycles = 0; completes = 0; n = 0; pulsed = 0;
        while (n < 40 && !(completes > 0 && digest_ready)) begin
            mem_stall    = 1'b0;
            digest_valid = 1'b0;
            if (h_vector_complete) completes++;
            if (h_write) begin
                wcycles++;
                check("wr_addr", 64'(h_output_address), 64'(idx));
                check("wr_data", 64'(h_data), 64'(word_of(exp_vec, idx)));
                if (idx == pulse_addr && !pulsed) begin
                    check("ready_while_busy", 64'(digest_ready), 64'(0));
                    digest_valid = 1'b1;
                    pulsed = 1;
                end
                if (idx == stall_addr && stalls < stall_len) begin
                    mem_stall = 1'b1;
                    stalls++;
                end else begin
                    idx++;
                end
            end
            tick();
            n++;
        end
        mem_stall    = 1'b0;
        digest_valid = 1'b0;
        check("drain_timeout", 64'(n >= 40), 64'(0));
        check("words_written", 64'(idx), 64'(8));
        check("write_cycles", 64'(wcycles), 64'(8 + stall_len));
        check("complete_pulses", 64'(completes), 64'(1));
        check("busy_after", 64'(busy), 64'(0));
    endtask

    vec_t         tbl [11];
    logic [255:0] iv_vec;
    logic [255:0] alt_vec;

    initial begin
        for (int i = 0; i < 8; i++) begin
            iv_vec[i*32 +: 32]  = IV[i];
            alt_vec[i*32 +: 32] = 32'h1000_0000 * (i + 1) + 32'h0000_abcd;
        end
        // Cycle table: inputs before edge k, expected outputs after edge k.
        tbl[0] = '{dv: 1, stall: 1, exp_write: 0, exp_addr: 0, exp_data: 0, exp_complete: 0, exp_ready: 0, exp_busy: 1};
        tbl[1] = '{dv: 0, stall: 1, exp_write: 1, exp_addr: 0, exp_data: IV[0], exp_complete: 0, exp_ready: 0, exp_busy: 1};
        for (int k = 2; k <= 8; k++)
            tbl[k] = '{dv: 0, stall: 0, exp_write: 1, exp_addr: 3'(k - 1), exp_data: IV[k-1], exp_complete: 0, exp_ready: 0, exp_busy: 1};
        tbl[9]  = '{dv: 0, stall: 0, exp_write: 0, exp_addr: 7, exp_data: 0, exp_complete: 1, exp_ready: 0, exp_busy: 1};
        tbl[10] = '{dv: 0, stall: 1, exp_write: 0, exp_addr: 7, exp_data: 0, exp_complete: 0, exp_ready: 1, exp_busy: 0};

        #12 reset = 1'b0;
        tick();
        check("rst_write", 64'(h_write), 64'(0));
        check("rst_addr", 64'(h_output_address), 64'(0));
        check("rst_data", 64'(h_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_complete", 64'(h_vector_complete), 64'(0));
        check("rst_ready", 64'(digest_ready), 64'(1));

        // Basic writeback from the table.
        enable      = 1'b1;
        hash_vector = iv_vec;
        for (int k = 0; k < 11; k++) begin
            digest_valid = tbl[k].dv;
            mem_stall    = tbl[k].stall;
            tick();
            check($sformatf("tbl%0d_write", k), 64'(h_write), 64'(tbl[k].exp_write));
            if (tbl[k].exp_write) begin
                check($sformatf("tbl%0d_addr", k), 64'(h_output_address), 64'(tbl[k].exp_addr));
                check($sformatf("tbl%0d_data", k), 64'(h_data), 64'(tbl[k].exp_data));
            end
            check($sformatf("tbl%0d_complete", k), 64'(h_vector_complete), 64'(tbl[k].exp_complete));
            check($sformatf("tbl%0d_ready", k), 64'(digest_ready), 64'(tbl[k].exp_ready));
            check($sformatf("tbl%0d_busy", k), 64'(busy), 64'(tbl[k].exp_busy));
        end
        digest_valid = 1'b0;
        mem_stall    = 1'b0;

        // Stall for 3 cycles on address 3.
        send_digest(alt_vec);
        drain(alt_vec, 3, 3, -1);

        // Input isolation: live vector changes right after capture.
        send_digest(iv_vec);
        hash_vector = '1;
        drain(iv_vec, -1, 0, -1);

        // Ignored start at address 4 with a different vector on the bus.
        send_digest(alt_vec);
        hash_vector = iv_vec;
        drain(alt_vec, -1, 0, 4);

        // Abort at address 5.
        send_digest(iv_vec);
        wait_addr(3'd5);
        enable = 1'b0;
        tick();
        check("abort_write", 64'(h_write), 64'(0));
        check("abort_complete", 64'(h_vector_complete), 64'(0));
        check("abort_ready", 64'(digest_ready), 64'(1));
        tick();
        check("abort_complete2", 64'(h_vector_complete), 64'(0));
        enable = 1'b1;
        send_digest(alt_vec);
        drain(alt_vec, -1, 0, -1);

        // Abort on the cycle of the final acceptance: no complete pulse.
        send_digest(iv_vec);
        wait_addr(3'd7);
        enable = 1'b0;
        tick();
        check("abort_last_write", 64'(h_write), 64'(0));
        check("abort_last_complete", 64'(h_vector_complete), 64'(0));
        check("abort_last_busy", 64'(busy), 64'(0));
        enable = 1'b1;
        tick();
        check("abort_last_complete2", 64'(h_vector_complete), 64'(0));

        // Asynchronous reset mid-cycle at address 2.
        send_digest(alt_vec);
        wait_addr(3'd2);
        #2 reset = 1'b1;
        #1;
        check("arst_write", 64'(h_write), 64'(0));
        check("arst_addr", 64'(h_output_address), 64'(0));
        check("arst_data", 64'(h_data), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_ready", 64'(digest_ready), 64'(1));
        @(negedge clock);
        reset = 1'b0;
        tick();
        send_digest(iv_vec);
        drain(iv_vec, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
